// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks (x,y) over the full line/frame and decodes sync,
// data-enable and start pulses from the same registered position.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_de,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_line_start,
   output logic       o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state_q, state_d;
   logic [9:0] x_d, y_d;
   logic       ls_d, fs_d, de_d, hs_d, vs_d, run_d;

   // Next position and its decode; outputs register together so they never skew.
   always_comb begin
      state_d = state_q;
      x_d     = o_x;
      y_d     = o_y;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (i_en) begin
         case (state_q)
            IDLE: begin
               state_d = RUN;
               x_d     = 10'd0;
               y_d     = 10'd0;
               ls_d    = 1'b1;
               fs_d    = 1'b1;
            end
            default: begin
               if (o_x == H_LAST) begin
                  x_d = 10'd0;
                  y_d = (o_y == V_LAST) ? 10'd0 : o_y + 10'd1;
               end else begin
                  x_d = o_x + 10'd1;
               end
               ls_d = (x_d == 10'd0);
               fs_d = (x_d == 10'd0) && (y_d == 10'd0);
            end
         endcase
      end
      run_d = (state_d == RUN);
      de_d  = run_d && (x_d < H_ACT) && (y_d < V_ACT);
      hs_d  = (run_d && (x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = (run_d && (y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         o_x           <= 10'd0;
         o_y           <= 10'd0;
         o_de          <= 1'b0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
         o_hsync       <= ~SYNC_POL;
         o_vsync       <= ~SYNC_POL;
      end else begin
         state_q       <= state_d;
         o_x           <= x_d;
         o_y           <= y_d;
         o_de          <= de_d;
         o_line_start  <= ls_d;
         o_frame_start <= fs_d;
         o_hsync       <= hs_d;
         o_vsync       <= vs_d;
      end
   end

endmodule
